cacheline_burst_adaptor: RTL
============================

Name: cacheline_burst_adaptor

Overview:
Memory-side responder for the L2 cache's physical-memory port. It accepts whole-line read and write requests (256-bit line, 32-bit address, level-held request, one-cycle response) from the L2 cache controller/datapath. It converts each request into a 4-beat, 64-bit burst transaction on the physical memory bus, then returns a single-cycle response to the cache. It sits between the L2 cache and main memory.

Parameters:
s_offset, 5, byte-offset bits within a line; the line is 2**s_offset bytes.
s_line, 256, line width in bits (8*2**s_offset).
s_burst, 64, burst beat width in bits.
n_beats, s_line/s_burst (4), beats per line. Derived; not to be overridden.

Ports:
clk  input  1  clock, all state on the rising edge
rst  input  1  synchronous active-high reset
pmem_address  input  32  line request address from the cache
pmem_wdata  input  s_line  line to write, from the cache
pmem_rdata  output  s_line  line read, to the cache
pmem_read  input  1  line read request, level-held until pmem_resp
pmem_write  input  1  line write request, level-held until pmem_resp
pmem_resp  output  1  one-cycle completion pulse to the cache
mem_address  output  32  line-aligned burst address
mem_rdata  input  s_burst  incoming read beat
mem_wdata  output  s_burst  outgoing write beat
mem_read  output  1  burst read request
mem_write  output  1  burst write request
mem_resp  input  1  beat accepted/valid strobe from memory

Behaviour:
- Reset: clk only, synchronous, active-high rst. All outputs are 0 on the cycle after rst is sampled high: pmem_rdata=0, pmem_resp=0, mem_address=0, mem_wdata=0, mem_read=0, mem_write=0. FSM goes to IDLE and the beat counter goes to 0. Reset mid-burst abandons the transaction and issues no pmem_resp.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If pmem_write is high: latch mem_address={pmem_address[31:s_offset], s_offset'b0} and latch pmem_wdata into the write buffer. Clear the counter and go to WRITE. pmem_write wins if pmem_read and pmem_write are both high.
  - Else if pmem_read is high: latch the address the same way and go to READ.
  - mem_resp is ignored in IDLE.
- READ:
  - mem_read=1 throughout.
  - Each cycle with mem_resp=1 stores mem_rdata into read buffer slice [64*k+63:64*k], where k is the counter, then increments k.
  - Beats may be separated by idle cycles (mem_resp=0); the counter holds during those cycles.
  - On the beat with k=n_beats-1, go to DONE.
  - mem_read drops to 0 in the cycle after the last beat.
- WRITE:
  - mem_write=1 throughout.
  - mem_wdata = write buffer slice k, driven combinationally from the counter.
  - Each mem_resp=1 advances k. On the beat with k=n_beats-1, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; mem_read=mem_write=0.
  - For reads, pmem_rdata = the assembled line (beat0 in bits 63:0).
  - Next state is IDLE unconditionally. The cache deasserts its request in the cycle after pmem_resp, so DONE must not re-sample requests.
- pmem_rdata holds its value until the next read completes; a write does not change it.
- mem_address is stable from the IDLE→READ/WRITE edge through DONE.
- Counter: width $clog2(n_beats), wraps to 0 on the last beat.
- Minimum latency, with mem_resp high on the first cycle of the burst: request sampled in IDLE at cycle 0, beats at cycles 1–4, pmem_resp at cycle 5.
- Requests arriving while not in IDLE have no effect until the FSM returns to IDLE.

Test Plan:
- Read, back-to-back beats: pmem_read=1, pmem_address=0x0000_1234. Memory returns beats 0x1111…1, 0x2222…2, 0x3333…3, 0x4444…4 on consecutive mem_resp cycles.
  → mem_address=0x0000_1220.
  → pmem_resp pulses once, one cycle after beat 4.
  → pmem_rdata = {0x4444…4, 0x3333…3, 0x2222…2, 0x1111…1}.
  → mem_read is low in the same cycle as pmem_resp.
- Read with gaps: mem_resp pattern 1,0,0,1,1,0,1.
  → pmem_resp arrives exactly one cycle after the 4th mem_resp.
  → The line is assembled correctly and no beat is duplicated.
- Write: pmem_write=1, pmem_wdata={D3,D2,D1,D0}, address 0x8000_00FF.
  → mem_address=0x8000_00E0.
  → mem_wdata=D0,D1,D2,D3 on successive mem_resp cycles.
  → A single pmem_resp is issued.
  → pmem_rdata is unchanged from the previous read.
- Simultaneous request: pmem_read=1 and pmem_write=1 in IDLE.
  → A write burst executes (mem_write=1, mem_read=0 throughout).
- Reset mid-burst: assert rst after 2 read beats.
  → Next cycle all outputs are 0 and the FSM is IDLE.
  → A following read completes normally with 4 fresh beats.
- Stray strobe and hold: mem_resp=1 while in IDLE with no request.
  → No state change and no pmem_resp.
  → A request held high through DONE generates only one transaction.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// Memory-side responder for the L2 cache physical-memory port.
//
// Accepts whole-line read/write requests from the L2 cache (level-held until
// pmem_resp) and turns each one into an n_beats-long burst on the physical
// memory bus, then answers the cache with a one-cycle pmem_resp.
//
// Ports (cache side):
//   clk, rst       clock and synchronous active-high reset
//   pmem_address   line request address
//   pmem_wdata     line to write
//   pmem_rdata     last line read; held until the next read completes
//   pmem_read      line read request
//   pmem_write     line write request (wins over pmem_read)
//   pmem_resp      one-cycle completion pulse
// Ports (memory side):
//   mem_address    line-aligned burst address, stable for the whole burst
//   mem_rdata      incoming read beat
//   mem_wdata      outgoing write beat
//   mem_read       burst read request
//   mem_write      burst write request
//   mem_resp       beat accepted / beat valid strobe

module cacheline_burst_adaptor #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_read,
  input  logic              pmem_write,
  output logic              pmem_resp,
  output logic [31:0]       mem_address,
  input  logic [s_burst-1:0] mem_rdata,
  output logic [s_burst-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_resp
);

  localparam int unsigned n_beats = s_line / s_burst;
  localparam int unsigned CntW    = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(n_beats - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [s_line-1:0]   wbuf_q, wbuf_d;
  logic [s_line-1:0]   rbuf_q, rbuf_d;
  logic [s_line-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    rbuf_d    = rbuf_q;
    rdata_d   = rdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    pmem_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mem_resp is deliberately ignored here; only cache requests matter.
        if (pmem_write) begin
          addr_d                = pmem_address;
          addr_d[s_offset-1:0]  = '0;
          wbuf_d                = pmem_wdata;
          cnt_d                 = '0;
          state_d               = StWrite;
        end else if (pmem_read) begin
          addr_d                = pmem_address;
          addr_d[s_offset-1:0]  = '0;
          cnt_d                 = '0;
          state_d               = StRead;
        end
      end

      StRead: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          rbuf_d[int'(cnt_q)*s_burst +: s_burst] = mem_rdata;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            // Publish the completed line so it is valid during the resp cycle.
            rdata_d = rbuf_d;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StWrite: begin
        mem_write = 1'b1;
        mem_wdata = wbuf_q[int'(cnt_q)*s_burst +: s_burst];
        if (mem_resp) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StDone: begin
        // The cache still holds its request this cycle; do not re-sample it.
        pmem_resp = 1'b1;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign pmem_rdata  = rdata_q;
  assign mem_address = addr_q;

endmodule
